// File: rtl/p03_uart_cmd_frontend_pkg.sv
// Shared types and constants for the p03 UART command front end.
// Split into global, FIFO, UART and processor packages.
package global_pkg;
    typedef logic [7:0] data_t;
endpackage

package fifo_pkg;
    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
endpackage

package uart_pkg;
    import global_pkg::*;
    localparam int    CLKS_PER_BIT = 16;
    localparam data_t START_BYTE   = 8'hFE;
    localparam data_t END_BYTE     = 8'hEF;
    localparam data_t ERR_BYTE     = 8'hEE;
    localparam data_t ACK_BYTE     = 8'hAC;
endpackage

package processor_pkg;
    import global_pkg::*;
    typedef enum logic [2:0] {
        WAIT_START = 3'd0,
        GET_LEN    = 3'd1,
        GET_CMD    = 3'd2,
        GET_DATA   = 3'd3,
        GET_END    = 3'd4,
        EXECUTE    = 3'd5
    } parser_state_t;
    localparam data_t CMD_SET_N   = 8'h01;
    localparam data_t CMD_LOAD_A  = 8'h02;
    localparam data_t CMD_DUMP_A  = 8'h03;
    localparam data_t CMD_CLEAR_A = 8'h04;
endpackage

// File: rtl/p03_uart_cmd_frontend_uart_tx_8n1.sv
// 8N1 UART serializer: start bit, 8 data bits LSB first, stop bit.
// Handshake: din is taken when start && accept; accept is also high in the last
// stop-bit cycle so consecutive characters follow with no idle gap.
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       accept,
    output logic       busy,
    output logic       tx,
    output logic [1:0] dbg_state
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t     state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    idx, idx_nx;
    logic [7:0]    sh, sh_nx;
    logic          tx_r, tx_nx;
    logic          bit_end;

    assign bit_end   = (cnt == CW'(CLKS_PER_BIT - 1));
    assign accept    = (state == TX_IDLE) || ((state == TX_STOP) && bit_end);
    assign busy      = (state != TX_IDLE);
    assign tx        = tx_r;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= TX_IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            tx_r  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            sh    <= sh_nx;
            tx_r  <= tx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = bit_end ? '0 : cnt + 1'b1;
        idx_nx   = idx;
        sh_nx    = sh;
        tx_nx    = tx_r;
        if (start && accept) begin
            state_nx = TX_START;
            cnt_nx   = '0;
            idx_nx   = '0;
            sh_nx    = din;
            tx_nx    = 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    cnt_nx = '0;
                    tx_nx  = 1'b1;
                end
                TX_START: if (bit_end) begin
                    state_nx = TX_DATA;
                    tx_nx    = sh[0];
                end
                TX_DATA: if (bit_end) begin
                    if (idx == 3'd7) begin
                        state_nx = TX_STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                        sh_nx  = {1'b0, sh[7:1]};
                        tx_nx  = sh[1];
                    end
                end
                TX_STOP: if (bit_end) begin
                    state_nx = TX_IDLE;
                    tx_nx    = 1'b1;
                end
                default: state_nx = TX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/p03_uart_cmd_frontend.sv
// Framed byte-command parser with payload FIFO A and UART dump path.
// Define P03_ERR_RESP_EN to send 0xEE on frame errors and 0xAC on SET_N/CLEAR_A success.
module p03_uart_cmd_frontend
    import global_pkg::*, processor_pkg::*;
#(
    parameter int FIFO_DEPTH   = fifo_pkg::FIFO_DEPTH,
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int MAX_N        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_interrupt,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       full_A,
    output logic       empty_A,
    output logic [2:0] dbg_state,
    output logic [1:0] dbg_tx_state,
    output logic [7:0] dbg_n,
    output logic       dbg_err
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic          rx_q, byte_v;
    data_t         byte_r;
    parser_state_t state, state_nx;
    data_t         count, count_nx, cmd, cmd_nx, n_buf, n_buf_nx, n_reg;
    logic          n_have, n_have_nx, dump_active;
    logic          push, pop, frame_err;
    logic          exec, set_n_ok, set_n_bad, unknown_cmd, clear_a, dump_go;
    data_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic          tx_start, tx_accept, tx_busy;
    data_t         tx_din;

    // One byte event per falling edge of the strobe; data is taken at that edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_q   <= 1'b0;
            byte_v <= 1'b0;
            byte_r <= '0;
        end else begin
            rx_q   <= rx_interrupt;
            byte_v <= rx_q & ~rx_interrupt;
            if (rx_q & ~rx_interrupt) byte_r <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= WAIT_START;
            count       <= '0;
            cmd         <= '0;
            n_buf       <= '0;
            n_have      <= 1'b0;
            n_reg       <= 8'd1;
            dump_active <= 1'b0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            cmd    <= cmd_nx;
            n_buf  <= n_buf_nx;
            n_have <= n_have_nx;
            if (set_n_ok) n_reg <= n_buf;
            if (dump_go) dump_active <= 1'b1;
            else if (empty_A) dump_active <= 1'b0;
        end
    end

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        cmd_nx    = cmd;
        n_buf_nx  = n_buf;
        n_have_nx = n_have;
        push      = 1'b0;
        frame_err = 1'b0;
        case (state)
            WAIT_START: if (byte_v && byte_r == uart_pkg::START_BYTE) state_nx = GET_LEN;
            GET_LEN: if (byte_v) begin
                if (byte_r < 8'd2) begin
                    frame_err = 1'b1;
                    state_nx  = WAIT_START;
                end else begin
                    count_nx = byte_r - 8'd2;
                    state_nx = GET_CMD;
                end
            end
            GET_CMD: if (byte_v) begin
                cmd_nx    = byte_r;
                n_have_nx = 1'b0;
                state_nx  = (count != 8'd0) ? GET_DATA : GET_END;
            end
            GET_DATA: if (byte_v) begin
                if (cmd == CMD_SET_N && !n_have) begin
                    n_buf_nx  = byte_r;
                    n_have_nx = 1'b1;
                end
                if (cmd == CMD_LOAD_A && !full_A) push = 1'b1;
                count_nx = count - 8'd1;
                if (count == 8'd1) state_nx = GET_END;
            end
            GET_END: if (byte_v) begin
                if (byte_r == uart_pkg::END_BYTE) begin
                    state_nx = EXECUTE;
                end else begin
                    frame_err = 1'b1;
                    state_nx  = WAIT_START;
                end
            end
            EXECUTE: state_nx = WAIT_START;
            default: state_nx = WAIT_START;
        endcase
    end

    assign exec        = (state == EXECUTE);
    assign set_n_ok    = exec && cmd == CMD_SET_N && n_have && n_buf != 8'd0 && n_buf <= 8'(MAX_N);
    assign set_n_bad   = exec && cmd == CMD_SET_N && !set_n_ok;
    assign unknown_cmd = exec && !(cmd inside {CMD_SET_N, CMD_LOAD_A, CMD_DUMP_A, CMD_CLEAR_A});
    assign clear_a     = exec && cmd == CMD_CLEAR_A;
    assign dump_go     = exec && cmd == CMD_DUMP_A;

    // FIFO A: occupancy counter makes simultaneous push/pop leave the level unchanged.
    always_ff @(posedge clk) begin
        if (!rst || clear_a) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= byte_r;
    end

    assign full_A  = (cnt == CNT_W'(FIFO_DEPTH));
    assign empty_A = (cnt == '0);

`ifdef P03_ERR_RESP_EN
    logic err_pend, ack_pend;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_pend <= 1'b0;
            ack_pend <= 1'b0;
        end else begin
            if (dbg_err) err_pend <= 1'b1;
            else if (tx_accept) err_pend <= 1'b0;
            if (set_n_ok || clear_a) ack_pend <= 1'b1;
            else if (tx_accept && !err_pend) ack_pend <= 1'b0;
        end
    end

    assign pop      = tx_accept && !err_pend && !ack_pend && dump_active && !empty_A;
    assign tx_start = tx_accept && (err_pend || ack_pend || (dump_active && !empty_A));
    assign tx_din   = err_pend ? uart_pkg::ERR_BYTE : (ack_pend ? uart_pkg::ACK_BYTE : mem[rd_ptr]);
    assign ready    = (state == WAIT_START) && !tx_busy && !dump_active && !err_pend && !ack_pend;
`else
    assign pop      = tx_accept && dump_active && !empty_A;
    assign tx_start = pop;
    assign tx_din   = mem[rd_ptr];
    assign ready    = (state == WAIT_START) && !tx_busy && !dump_active;
`endif

    uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .start     (tx_start),
        .din       (tx_din),
        .accept    (tx_accept),
        .busy      (tx_busy),
        .tx        (tx),
        .dbg_state (dbg_tx_state)
    );

    assign dbg_state = state;
    assign dbg_n     = n_reg;
    assign dbg_err   = frame_err | set_n_bad | unknown_cmd;
endmodule

// File: tb/tb_p03_uart_cmd_frontend.sv
// Bench for p03_uart_cmd_frontend: table of frames with expected N/FIFO flags/tx bytes,
// plus sequences for strobe timing, dump/load overlap and reset during transmission.
module tb_p03_uart_cmd_frontend;
    localparam int CPB = 16;
`ifdef P03_ERR_RESP_EN
    localparam bit RESP = 1'b1;
`else
    localparam bit RESP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_interrupt = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx, ready, full_A, empty_A, dbg_err;
    logic [2:0] dbg_state;
    logic [1:0] dbg_tx_state;
    logic [7:0] dbg_n;

    always #5 clk = ~clk;

    p03_uart_cmd_frontend dut (
        .clk          (clk),
        .rst          (rst),
        .rx_interrupt (rx_interrupt),
        .data         (data),
        .tx           (tx),
        .ready        (ready),
        .full_A       (full_A),
        .empty_A      (empty_A),
        .dbg_state    (dbg_state),
        .dbg_tx_state (dbg_tx_state),
        .dbg_n        (dbg_n),
        .dbg_err      (dbg_err)
    );

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [127:0] frame;
        int           nb;
        logic [63:0]  txb;
        int           ntx;
        int           resp;  // 0 none, 1 error byte, 2 ack byte
        logic [7:0]   exp_n;
        logic         exp_empty;
        logic         exp_full;
    } vec_t;

    vec_t vecs[20];
    int   nvec;

    // Serial receiver: mid-bit sampling off the start-bit falling edge.
    initial begin : tx_monitor
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge tx);
            repeat (CPB / 2) @(posedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(posedge clk);
                b[k] = tx;
            end
            repeat (CPB) @(posedge clk);
            got_q.push_back(b);
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp_v);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        data = b;
        rx_interrupt = 1'b1;
        tick(2);
        rx_interrupt = 1'b0;
        tick(4);
    endtask

    task automatic send_frame(input logic [127:0] fr, input int nb);
        logic [7:0] b;
        for (int i = 0; i < nb; i++) begin
            b = fr[8*(nb-1-i) +: 8];
            send_byte(b);
        end
    endtask

    task automatic wait_ready(input string tag);
        int t;
        t = 0;
        while (ready !== 1'b1 && t < 4000) begin
            tick(1);
            t++;
        end
        chk({tag, " ready"}, 32'(ready), 32'd1);
        tick(2);
    endtask

    task automatic check_tx(input string tag);
        chk({tag, " tx_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, " tx_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push_resp(input int kind);
        if (RESP && kind == 1) exp_q.push_back(8'hEE);
        if (RESP && kind == 2) exp_q.push_back(8'hAC);
    endtask

    initial begin : main
        string tag;
        logic [7:0] b;
        nvec = 0;
        vecs[nvec++] = '{128'hFE030104EF,               5,  64'h0,               0, 2, 8'd4, 1'b1, 1'b0};
        vecs[nvec++] = '{128'hFE0502112233EF,           7,  64'h0,               0, 0, 8'd4, 1'b0, 1'b0};
        vecs[nvec++] = '{128'hFE0203EF,                 4,  64'h112233,          3, 0, 8'd4, 1'b1, 1'b0};
        vecs[nvec++] = '{128'hFE0B02A0A1A2A3A4A5A6A7A8EF, 13, 64'h0,             0, 0, 8'd4, 1'b0, 1'b1};
        vecs[nvec++] = '{128'hFE0203EF,                 4,  64'hA0A1A2A3A4A5A6A7, 8, 0, 8'd4, 1'b1, 1'b0};
        vecs[nvec++] = '{128'hFE03010655,               5,  64'h0,               0, 1, 8'd4, 1'b1, 1'b0};
        vecs[nvec++] = '{128'h1234FE030102EF,           7,  64'h0,               0, 2, 8'd2, 1'b1, 1'b0};
        vecs[nvec++] = '{128'hFE030109EF,               5,  64'h0,               0, 1, 8'd2, 1'b1, 1'b0};
        vecs[nvec++] = '{128'hFE030100EF,               5,  64'h0,               0, 1, 8'd2, 1'b1, 1'b0};
        vecs[nvec++] = '{128'hFE01,                     2,  64'h0,               0, 1, 8'd2, 1'b1, 1'b0};
        vecs[nvec++] = '{128'hFE0207EF,                 4,  64'h0,               0, 1, 8'd2, 1'b1, 1'b0};
        vecs[nvec++] = '{128'hFE04025566EF,             6,  64'h0,               0, 0, 8'd2, 1'b0, 1'b0};
        vecs[nvec++] = '{128'hFE0204EF,                 4,  64'h0,               0, 2, 8'd2, 1'b1, 1'b0};
        vecs[nvec++] = '{128'hFE0203EF,                 4,  64'h0,               0, 0, 8'd2, 1'b1, 1'b0};
        vecs[nvec++] = '{128'hFE04010309EF,             6,  64'h0,               0, 2, 8'd3, 1'b1, 1'b0};
        vecs[nvec++] = '{128'hFE03027700,               5,  64'h0,               0, 1, 8'd3, 1'b0, 1'b0};
        vecs[nvec++] = '{128'hFE0203EF,                 4,  64'h77,              1, 0, 8'd3, 1'b1, 1'b0};
        vecs[nvec++] = '{128'hFE030108EF,               5,  64'h0,               0, 2, 8'd8, 1'b1, 1'b0};

        // Reset held low for one cycle.
        tick(1);
        chk("reset tx", 32'(tx), 32'd1);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset empty_A", 32'(empty_A), 32'd1);
        chk("reset full_A", 32'(full_A), 32'd0);
        chk("reset n", 32'(dbg_n), 32'd1);
        chk("reset state", 32'(dbg_state), 32'd0);
        rst = 1'b1;
        tick(2);

        for (int i = 0; i < nvec; i++) begin
            tag = $sformatf("vec%0d", i);
            push_resp(vecs[i].resp);
            for (int k = 0; k < vecs[i].ntx; k++) begin
                b = vecs[i].txb[8*(vecs[i].ntx-1-k) +: 8];
                exp_q.push_back(b);
            end
            send_frame(vecs[i].frame, vecs[i].nb);
            wait_ready(tag);
            chk({tag, " n"}, 32'(dbg_n), 32'(vecs[i].exp_n));
            chk({tag, " empty_A"}, 32'(empty_A), 32'(vecs[i].exp_empty));
            chk({tag, " full_A"}, 32'(full_A), 32'(vecs[i].exp_full));
            check_tx(tag);
        end

        // Only the value present at the falling edge is a byte: FE then 12 yields 12.
        data = 8'hFE;
        rx_interrupt = 1'b1;
        tick(1);
        data = 8'h12;
        tick(1);
        rx_interrupt = 1'b0;
        tick(4);
        send_frame(128'h030106EF, 4);
        wait_ready("late_change");
        chk("late_change n", 32'(dbg_n), 32'd8);
        check_tx("late_change");

        // 00 then FE while high yields FE.
        data = 8'h00;
        rx_interrupt = 1'b1;
        tick(2);
        data = 8'hFE;
        tick(1);
        rx_interrupt = 1'b0;
        tick(4);
        push_resp(2);
        send_frame(128'h030105EF, 4);
        wait_ready("edge_value");
        chk("edge_value n", 32'(dbg_n), 32'd5);
        check_tx("edge_value");

        // Load arriving while a dump is draining FIFO A.
        send_frame(128'hFE0502112233EF, 7);
        send_frame(128'hFE0203EF, 4);
        send_frame(128'hFE030299EF, 5);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h99);
        wait_ready("overlap");
        chk("overlap empty_A", 32'(empty_A), 32'd1);
        check_tx("overlap");

        // Reset in the middle of a character.
        send_frame(128'hFE04025A5BEF, 6);
        send_frame(128'hFE0203EF, 4);
        tick(50);
        rst = 1'b0;
        tick(1);
        chk("midtx_reset tx", 32'(tx), 32'd1);
        chk("midtx_reset empty_A", 32'(empty_A), 32'd1);
        chk("midtx_reset ready", 32'(ready), 32'd1);
        chk("midtx_reset n", 32'(dbg_n), 32'd1);
        rst = 1'b1;
        tick(300);
        got_q.delete();
        exp_q.delete();
        chk("post_reset tx idle", 32'(tx), 32'd1);
        push_resp(2);
        send_frame(128'hFE030107EF, 5);
        wait_ready("post_reset");
        chk("post_reset n", 32'(dbg_n), 32'd7);
        check_tx("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/p03_uart_cmd_frontend.md
Name: p03_uart_cmd_frontend

Overview:
- Byte-level command front end for the p03 processor.
- Receives bytes through a receive-interrupt strobe plus a parallel data bus, parses framed commands, and stores payload into FIFO A.
- Streams FIFO A contents back out of a serial UART transmitter on request.
- Sits between the UART receiver (stubbed at this level) and the processing core.

Parameters:
- FIFO_DEPTH, 8, entries in FIFO A (power of two).
- CLKS_PER_BIT, 16, clock cycles per UART bit on tx.
- MAX_N, 8, largest legal size value for CMD 0x01.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-low reset.
- rx_interrupt  input  1  receive strobe; byte valid while high, consumed on falling edge.
- data  input  8  received byte (data_t).
- tx  output  1  UART 8N1 serial out, idle high.
- ready  output  1  high when parser is in WAIT_START and the transmitter is idle.
- full_A  output  1  FIFO A full.
- empty_A  output  1  FIFO A empty.

Behaviour:
- One clock domain; reset is synchronous and active-low.
- Reset values: tx=1, ready=1, full_A=0, empty_A=1. FIFO pointers clear, parser goes to WAIT_START, stored N=1.
- Byte capture:
  - rx_interrupt is registered; a high-to-low transition generates one byte event.
  - data is sampled in the cycle the falling edge is detected, so the byte is latched one clock after the falling edge.
  - data may change while rx_interrupt is high; only the value at the falling edge counts.
- Frame format: 0xFE, L, CMD, payload[L-2], 0xEF.
  - L counts the L byte, the CMD byte and the payload bytes. Example: FE 03 01 04 EF carries a one-byte payload.
- Parser states and transitions:
  - WAIT_START: advance to GET_LEN on 0xFE; ignore all other bytes.
  - GET_LEN: if L<2, go to WAIT_START. Otherwise latch L, set count=L-2, go to GET_CMD.
  - GET_CMD: latch CMD. Go to GET_DATA if count>0, else GET_END.
  - GET_DATA: on each byte, act per CMD and decrement count. Go to GET_END when count reaches 0.
  - GET_END: if byte is 0xEF, commit and go to EXECUTE; otherwise raise a frame error and go to WAIT_START.
  - EXECUTE: perform the command for one cycle, then go to WAIT_START.
- Commands:
  - 0x01 SET_N: first payload byte is buffered and committed to N on a good end byte if 1..MAX_N. Otherwise error, N unchanged.
  - 0x02 LOAD_A: each payload byte is pushed to FIFO A as it arrives. When full_A, the byte is dropped and FIFO state is unchanged. Pushes are not undone on a bad end byte.
  - 0x03 DUMP_A: on commit, pop FIFO A entries one at a time and transmit each until empty_A. A dump with empty FIFO sends nothing.
  - 0x04 CLEAR_A: on commit, reset FIFO A pointers (empty_A=1 next cycle).
  - Any other CMD: error on commit, no action.
- FIFO A:
  - Synchronous, first-word fall-through not required.
  - Pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop when not empty keeps the count unchanged.
  - Pop when empty is ignored.
- UART TX:
  - Format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts CLKS_PER_BIT cycles.
  - The next byte starts directly after the stop bit.
- Events during a dump: bytes received during a dump are still parsed, but LOAD_A pushes collide with the pop; both operations are performed in the same cycle.
- Reset mid-frame or mid-transmission: everything aborts, and tx returns high on the next edge.

Optional Feature:
- Macro P03_ERR_RESP_EN.
- Defined: every frame error (bad L, bad end byte, illegal N, unknown CMD) queues one 0xEE byte on tx. Every successful SET_N or CLEAR_A queues one ack byte 0xAC. Acks and errors have priority over dump bytes between characters.
- Undefined: errors are silent and tx carries only dump data.

Decomposition:
- global_pkg: data_t (logic [7:0]).
- fifo_pkg: FIFO_DEPTH and the pointer width.
- uart_pkg: CLKS_PER_BIT, START_BYTE 0xFE, END_BYTE 0xEF, ERR_BYTE 0xEE, ACK_BYTE 0xAC.
- processor_pkg: parser state enum and command codes 0x01 to 0x04.
- Sub-module: uart_tx_8n1 (serializer with start, ready-busy handshake). The FIFO is inline or a reused fifo module.

Test Plan:
- Reset: rst=0 for 1 cycle -> tx=1, ready=1, empty_A=1, full_A=0.
- Frame FE 03 01 04 EF with each byte held while rx_interrupt high and dropped -> N=4, empty_A stays 1, ready returns 1 after EXECUTE.
- Frame FE 05 02 11 22 33 EF, then FE 02 03 EF -> empty_A=0 after load; tx emits 0x11, 0x22, 0x33 serially; empty_A=1 after the third pop.
- LOAD_A of 9 bytes with FIFO_DEPTH=8 -> full_A=1 after the 8th byte, 9th dropped; dump returns exactly 8 bytes.
- Bad end byte FE 03 01 04 55 -> N unchanged; with P03_ERR_RESP_EN, tx sends 0xEE.
- Stray bytes 12 34 before FE 03 01 02 EF -> ignored; N=2.
